// File: rtl/gry_pkg.sv
// Shared types and helpers for the sequential Gray-to-binary decoder.
package gry_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned step_count(input int unsigned n, input int unsigned bpc);
        return (n + bpc - 1) / bpc;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gry_bin_dec_if.sv
// Input/output handshake bundle of the Gray-to-binary decoder.
interface gry_bin_dec_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] gray_in;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] binary_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         step_err;

    modport master (
        output gray_in, in_valid, out_ready,
        input  in_ready, binary_out, out_valid, busy, step_err
    );

    modport slave (
        input  gray_in, in_valid, out_ready,
        output in_ready, binary_out, out_valid, busy, step_err
    );
endinterface

// File: rtl/gry_step_chk.sv
// Flags accepted Gray words whose Hamming distance to the previous word is not exactly 1.
module gry_step_chk
    import gry_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hs_i,
    input  logic [N-1:0] gray_i,
    output logic         err_o
);

    logic [N-1:0] prev_q, prev_d;
    logic         seen_q, seen_d;
    logic         err_q, err_d;

    always_comb begin
        prev_d = prev_q;
        seen_d = seen_q;
        err_d  = 1'b0;
        if (hs_i) begin
            prev_d = gray_i;
            seen_d = 1'b1;
            err_d  = seen_q && (popcount(MAX_W'(gray_i ^ prev_q)) != 32'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '0;
            seen_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/gry_bin_dec.sv
// Iterative MSB-first Gray-to-binary decoder, BPC bits per cycle, valid/ready on both sides.
// Optional Gray step checker enabled by defining GRY_STEP_CHK_EN.
module gry_bin_dec
    import gry_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned BPC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    gry_bin_dec_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(N);

    state_e             state_q, state_d;
    logic [N-1:0]       g_q, g_d;
    logic [N-1:0]       b_q, b_d;
    logic               r_q, r_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               r_run;
    logic [IDX_W-1:0]   sel;
    logic               hs_c;
    logic               step_err_c;

    assign hs_c = in_ready_q && bus.in_valid;

    // Next state and XOR-prefix datapath; r carries the last resolved binary bit downward.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        b_d     = b_q;
        r_d     = r_q;
        idx_d   = idx_q;
        r_run   = r_q;
        sel     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    g_d     = bus.gray_in;
                    b_d     = '0;
                    r_d     = 1'b0;
                    idx_d   = IDX_W'(N - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int j = 0; j < int'(BPC); j++) begin
                    if (int'(idx_q) >= j) begin
                        sel      = IDX_W'(int'(idx_q) - j);
                        r_run    = r_run ^ g_q[sel];
                        b_d[sel] = r_run;
                    end
                end
                r_d = r_run;
                if (int'(idx_q) < int'(BPC)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(BPC);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            b_q         <= '0;
            r_q         <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            b_q         <= b_d;
            r_q         <= r_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef GRY_STEP_CHK_EN
    gry_step_chk #(
        .N (N)
    ) u_step_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .hs_i   (hs_c),
        .gray_i (bus.gray_in),
        .err_o  (step_err_c)
    );
`else
    assign step_err_c = 1'b0;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.binary_out = b_q;
    assign bus.step_err   = step_err_c;

endmodule

// File: tb/tb_gry_bin_dec.sv
// Randomized self-checking bench for gry_bin_dec against a prefix-XOR reference model.
module tb_gry_bin_dec;

    localparam int unsigned N     = 8;
    localparam int unsigned BPC   = 3;
    localparam int unsigned STEPS = (N + BPC - 1) / BPC;
`ifdef GRY_STEP_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gry_bin_dec_if #(.N(N)) bus();

    gry_bin_dec #(
        .N   (N),
        .BPC (BPC)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           n_vec  = 0;
    int           n_err  = 0;
    logic [N-1:0] prev_m = '0;
    bit           seen_m = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Binary value is the XOR of all right shifts of the Gray word.
    function automatic logic [N-1:0] ref_decode(input logic [N-1:0] g);
        logic [N-1:0] acc;
        acc = '0;
        for (int k = 0; k < int'(N); k++) begin
            acc = acc ^ (g >> k);
        end
        return acc;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  32'(bus.in_ready),   32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid),  32'd0);
        check_eq("rst_busy",      32'(bus.busy),       32'd0);
        check_eq("rst_binary",    32'(bus.binary_out), 32'd0);
        check_eq("rst_step_err",  32'(bus.step_err),   32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        seen_m = 1'b0;
        prev_m = '0;
    endtask

    task automatic run_job(input logic [N-1:0] g, input logic [N-1:0] exp_b, input int hold);
        logic exp_err;
        int   lat;
        exp_err = CHK_EN && seen_m && ($countones(g ^ prev_m) != 1);
        prev_m  = g;
        seen_m  = 1'b1;
        @(negedge clk);
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.gray_in   = g;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq("step_err", 32'(bus.step_err), 32'(exp_err));
        check_eq("busy",     32'(bus.busy),     32'd1);
        lat = 0;
        while (!bus.out_valid && lat < int'(4 * STEPS)) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) check_eq("step_err_drop", 32'(bus.step_err), 32'd0);
        end
        check_eq("latency",    32'(lat),            32'(STEPS));
        check_eq("binary_out", 32'(bus.binary_out), 32'(exp_b));
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = c[0];
            bus.gray_in  = ~g;
            @(posedge clk);
            #1;
            check_eq("stall_valid",  32'(bus.out_valid),  32'd1);
            check_eq("stall_ready",  32'(bus.in_ready),   32'd0);
            check_eq("stall_binary", 32'(bus.binary_out), 32'(exp_b));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("out_drop",  32'(bus.out_valid), 32'd0);
        check_eq("ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic reset_mid_busy(input logic [N-1:0] g);
        bit stale;
        @(negedge clk);
        bus.gray_in  = g;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_out_valid", 32'(bus.out_valid),  32'd0);
        check_eq("abort_binary",    32'(bus.binary_out), 32'd0);
        check_eq("abort_in_ready",  32'(bus.in_ready),   32'd1);
        check_eq("abort_busy",      32'(bus.busy),       32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        seen_m = 1'b0;
        prev_m = '0;
        stale  = 1'b0;
        repeat (2 * STEPS + 2) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        check_eq("abort_no_stale", 32'(stale), 32'd0);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] b;
        logic [N-1:0] step_seq [6];
        bus.gray_in   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        do_reset();

        run_job(8'h8F, 8'hF5, 0);
        run_job(8'h00, 8'h00, 0);
        run_job(8'h80, 8'hFF, 0);

        // Step checker sequence from a fresh reset; the last two words are flagged when enabled.
        do_reset();
        step_seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h00, 8'h00};
        foreach (step_seq[i]) begin
            g = step_seq[i];
            run_job(g, ref_decode(g), 0);
        end

        for (int v = 0; v < 256; v++) begin
            b = N'(v);
            g = b ^ (b >> 1);
            run_job(g, b, 0);
        end

        run_job(8'hC0, 8'h80, 5);

        reset_mid_busy(8'h5A);
        run_job(8'h5A, ref_decode(8'h5A), 0);

        for (int t = 0; t < 40; t++) begin
            g = N'($urandom);
            run_job(g, ref_decode(g), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gry_bin_dec.md
Name: gry_bin_dec

Overview:
- Sequential Gray-to-binary decoder; the receive-side counterpart of the team's binary-to-Gray encoder.
- Accepts an N-bit Gray word over a valid/ready handshake and resolves it MSB-first, BPC bits per clock, through an iterative XOR chain.
- Presents the binary result over a valid/ready handshake.
- Used where Gray-coded values arrive from the encoder side, e.g. CDC pointer synchronizers and position encoders, and fmax matters more than latency.

Parameters:
- N, 8, width of Gray input and binary output (N >= 2).
- BPC, 1, bits resolved per BUSY cycle (1 <= BPC <= N); the last step resolves the remaining N mod BPC bits if nonzero.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous active-low reset.
- gray_in  input  N  Gray-coded word; sampled on input handshake.
- in_valid  input  1  gray_in valid.
- in_ready  output  1  decoder can accept a word.
- binary_out  output  N  decoded binary word.
- out_valid  output  1  binary_out holds a finished result.
- out_ready  input  1  downstream accepts result.
- busy  output  1  high in BUSY or DONE.
- step_err  output  1  Gray step violation pulse; see Optional Feature. Port is always present and tied 0 when the feature is off.

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, binary_out=0, step_err=0.
  - All internal registers are cleared.
- FSM states: IDLE, BUSY, DONE. in_ready=1 only in IDLE; there is no overlap of jobs.
- IDLE:
  - On in_valid&&in_ready, capture gray_in into g_q, clear the result register, set the running bit r=0 and the index to N-1, and go to BUSY.
  - in_valid is ignored in every state other than IDLE.
- BUSY: each cycle, for the next BPC indices i going downward, compute b[i] = r ^ g_q[i], then r = b[i].
  - When index 0 has been resolved, go to DONE.
  - BUSY lasts exactly ceil(N/BPC) cycles.
- DONE:
  - out_valid=1 and binary_out is stable.
  - Hold indefinitely while out_ready=0.
  - On out_valid&&out_ready, go to IDLE at the next edge and drop out_valid.
- Latency: with the input handshake at edge k, out_valid rises after edge k+ceil(N/BPC).
  - The earliest next input handshake is one cycle after the output handshake.
- binary_out keeps its last result after leaving DONE; it is meaningful only while out_valid=1.
- Arithmetic: pure XOR prefix from the MSB, so b[N-1] = g[N-1]. Widths are exact; no carries and no wrap.
- Reset mid-BUSY or mid-DONE aborts the job, and the result is discarded; no out_valid is produced for it.
- Simultaneous in_valid and out_ready in DONE: only the output handshake occurs; the input waits for IDLE.

Optional Feature:
- Macro: GRY_STEP_CHK_EN.
- Defined:
  - A register holds the previously accepted Gray word plus a "seen" flag, both cleared by reset.
  - On each input handshake with seen=1, if popcount(gray_in ^ prev) != 1 (a distance of 0 counts as an error), step_err pulses high for exactly one cycle. The pulse is in the cycle following the handshake.
  - prev is updated on every handshake. The first word after reset is never flagged.
- Not defined: step_err is constant 0, and no prev/seen registers are built.
- The decode datapath and latency are identical in both cases.

Decomposition:
- Package gry_pkg:
  - FSM state enum (IDLE, BUSY, DONE).
  - Function for step count ceil(N/BPC).
  - popcount function.
  - Step index width.
- Sub-module gry_step_chk holds the prev/seen registers and the distance-1 compare; it is instantiated only under GRY_STEP_CHK_EN.

Test Plan:
- Basic decode, N=8, BPC=1, out_ready=1:
  - gray_in 0x8F -> binary_out 0xF5, out_valid rising 8 cycles after the handshake.
  - gray_in 0x00 -> 0x00.
  - gray_in 0x80 -> 0xFF.
- Exhaustive check, N=8, BPC=3: all 256 encoder outputs (b ^ (b>>1)) fed in -> each decodes back to b, with latency 3 cycles every time.
- Backpressure: decode 0xC0, hold out_ready=0 for 5 cycles -> out_valid=1 and binary_out=0x80 stable throughout, in_ready=0; in_valid pulses during the stall are ignored.
- Reset mid-operation: assert rst_n=0 in BUSY cycle 4 -> next cycle state IDLE, out_valid=0, binary_out=0, in_ready=1; no stale result ever appears.
- Step check with GRY_STEP_CHK_EN defined: sequence 0x00, 0x01, 0x03, 0x07 (distances 1, 1, 1, no error), then 0x00 (distance 3) -> step_err one-cycle pulse after the 5th handshake only. Repeating 0x00 (distance 0) -> another pulse.
- Step check with GRY_STEP_CHK_EN undefined: same sequence -> step_err stays 0 throughout.
